// File: rtl/rv6_pkg.sv
// Shared constants and helpers for the integer register file and its scoreboard.
// Build option: REGFILE_BYPASS_EN enables same-cycle write-back forwarding in regfile_sb.
package rv6_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int REG_AW   = $clog2(NREG_DEF);

  // Write-back port indices; the LSU port is the later writer and wins collisions.
  localparam int WB_ALU   = 0;
  localparam int WB_LSU   = 1;
  localparam int NWB      = 2;

  // Widest busy vector the popcount helper accepts.
  localparam int POP_MAX  = 1024;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit scoreboard: tracks pending destination writes, gates WAW issue and
// keeps a registered count of busy registers.
module regfile_scoreboard
  import rv6_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_iss_vld,
  input  logic [AW-1:0]     i_iss_rd,
  output logic              o_iss_rdy,
  input  logic [NWB-1:0]    i_wb_vld,
  input  logic [NWB*AW-1:0] i_wb_rd,
  input  logic              i_flush,
  output logic [NREG-1:0]   o_busy,
  output logic [AW:0]       o_busy_cnt
);

  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_busy_cnt;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_busy_next;
  logic [AW-1:0]   w_wb_rd_alu;
  logic [AW-1:0]   w_wb_rd_lsu;
  logic            w_fire;

  assign w_wb_rd_alu = i_wb_rd[WB_ALU*AW +: AW];
  assign w_wb_rd_lsu = i_wb_rd[WB_LSU*AW +: AW];

  // Stall decision looks only at pre-edge busy, so a same-cycle write-back never releases it.
  assign o_iss_rdy = !i_flush && ((i_iss_rd == '0) || !r_busy[i_iss_rd]);
  assign w_fire    = i_iss_vld && o_iss_rdy;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    if (gi == 0) begin : g_x0
      assign w_set[gi]       = 1'b0;
      assign w_clr[gi]       = 1'b0;
      assign w_busy_next[gi] = 1'b0;
    end else begin : g_xn
      assign w_set[gi] = w_fire && (i_iss_rd == AW'(gi));
      assign w_clr[gi] = (i_wb_vld[WB_ALU] && (w_wb_rd_alu == AW'(gi))) ||
                         (i_wb_vld[WB_LSU] && (w_wb_rd_lsu == AW'(gi)));
      // Issue set dominates a write-back clear; flush dominates both.
      assign w_busy_next[gi] = i_flush ? 1'b0 : ((r_busy[gi] & ~w_clr[gi]) | w_set[gi]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= (AW+1)'(popcount(POP_MAX'(w_busy_next)));
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with busy-bit scoreboard and two write-back ports (ALU, LSU).
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regfile_sb
  import rv6_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int RD_PORTS = 2,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RD_PORTS*AW-1:0]   rs,
  output logic [RD_PORTS*XLEN-1:0] r,
  output logic [RD_PORTS-1:0]      r_rdy,
  input  logic                     iss_vld,
  input  logic [AW-1:0]            iss_rd,
  output logic                     iss_rdy,
  input  logic [NWB-1:0]           wb_vld,
  input  logic [NWB*AW-1:0]        wb_rd,
  input  logic [NWB*XLEN-1:0]      wb_d,
  input  logic                     flush,
  output logic [AW:0]              busy_cnt
);

  if ((NREG < 2) || ((NREG & (NREG - 1)) != 0) || (NREG > POP_MAX)) begin : g_bad_nreg
    $error("regfile_sb: NREG must be a power of two between 2 and %0d", POP_MAX);
  end
  if ((RD_PORTS < 1) || (RD_PORTS > 4)) begin : g_bad_ports
    $error("regfile_sb: RD_PORTS must be 1..4");
  end

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] w_busy;

  regfile_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_iss_vld  (iss_vld),
    .i_iss_rd   (iss_rd),
    .o_iss_rdy  (iss_rdy),
    .i_wb_vld   (wb_vld),
    .i_wb_rd    (wb_rd),
    .i_flush    (flush),
    .o_busy     (w_busy),
    .o_busy_cnt (busy_cnt)
  );

  // Ports are applied in index order, so the LSU port wins a same-register collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int p = 0; p < NWB; p++) begin
        if (wb_vld[p] && (wb_rd[p*AW +: AW] != '0)) begin
          r_regs[wb_rd[p*AW +: AW]] <= wb_d[p*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
    logic [AW-1:0]   w_rs;
    logic [XLEN-1:0] w_rd_data;
    logic            w_rd_rdy;

    assign w_rs = rs[gi*AW +: AW];

    always_comb begin
      w_rd_data = (w_rs == '0) ? '0 : r_regs[w_rs];
      w_rd_rdy  = (w_rs == '0) || !w_busy[w_rs];
`ifdef REGFILE_BYPASS_EN
      if (w_rs != '0) begin
        for (int p = 0; p < NWB; p++) begin
          if (wb_vld[p] && (wb_rd[p*AW +: AW] == w_rs)) begin
            w_rd_data = wb_d[p*XLEN +: XLEN];
            w_rd_rdy  = 1'b1;
          end
        end
      end
`endif
    end

    assign r[gi*XLEN +: XLEN] = w_rd_data;
    assign r_rdy[gi]          = w_rd_rdy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int XLEN = 64;
  localparam int AW   = 5;

  localparam int S_R0    = 0;
  localparam int S_R1    = 1;
  localparam int S_RDY0  = 2;
  localparam int S_RDY1  = 3;
  localparam int S_ISS   = 4;
  localparam int S_BCNT  = 5;

  logic              clk;
  logic              rst;
  logic [2*AW-1:0]   rs;
  logic [2*XLEN-1:0] r;
  logic [1:0]        r_rdy;
  logic              iss_vld;
  logic [AW-1:0]     iss_rd;
  logic              iss_rdy;
  logic [1:0]        wb_vld;
  logic [2*AW-1:0]   wb_rd;
  logic [2*XLEN-1:0] wb_d;
  logic              flush;
  logic [AW:0]       busy_cnt;

  regfile_sb dut (
    .clk      (clk),
    .rst      (rst),
    .rs       (rs),
    .r        (r),
    .r_rdy    (r_rdy),
    .iss_vld  (iss_vld),
    .iss_rd   (iss_rd),
    .iss_rdy  (iss_rdy),
    .wb_vld   (wb_vld),
    .wb_rd    (wb_rd),
    .wb_d     (wb_d),
    .flush    (flush),
    .busy_cnt (busy_cnt)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic [63:0] mon_act;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(input int sel);
    case (sel)
      S_R0:    return r[63:0];
      S_R1:    return r[127:64];
      S_RDY0:  return 64'(r_rdy[0]);
      S_RDY1:  return 64'(r_rdy[1]);
      S_ISS:   return 64'(iss_rdy);
      default: return 64'(busy_cnt);
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e   = q.pop_front();
      mon_act = actual(mon_e.sel);
      checks++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d (queued %0d) got=%h want=%h",
                 mon_e.name, cyc, mon_e.cyc, mon_act, mon_e.exp);
      end
    end
  end

  // Same-register dual write-back is illegal use; flag it without stopping the run.
  always @(negedge clk) begin
    if (!rst && wb_vld == 2'b11 && wb_rd[4:0] == wb_rd[9:5] && wb_rd[4:0] != 5'd0)
      $display("note: illegal dual write-back to x%0d at cyc %0d", wb_rd[4:0], cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic expect_out(input string name, input int sel, input logic [63:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  task automatic idle();
    iss_vld = 1'b0;
    wb_vld  = 2'b00;
    flush   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_rs(input logic [4:0] a, input logic [4:0] b);
    rs = {b, a};
  endtask

  task automatic wb(input int p, input logic [4:0] rd, input logic [63:0] d);
    wb_vld[p]          = 1'b1;
    wb_rd[p*AW +: AW]  = rd;
    wb_d[p*XLEN +: XLEN] = d;
  endtask

  task automatic iss(input logic [4:0] rd);
    iss_vld = 1'b1;
    iss_rd  = rd;
  endtask

  initial begin
    rst = 1'b1;
    rs = '0; iss_rd = '0; wb_rd = '0; wb_d = '0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: every register reads zero and ready on both ports
    for (int i = 0; i < 32; i++) begin
      set_rs(5'(i), 5'(31 - i));
      expect_out("rst_r0", S_R0, 64'd0);
      expect_out("rst_r1", S_R1, 64'd0);
      expect_out("rst_rdy0", S_RDY0, 64'd1);
      expect_out("rst_rdy1", S_RDY1, 64'd1);
      if (i == 0) begin
        expect_out("rst_bcnt", S_BCNT, 64'd0);
        expect_out("rst_iss", S_ISS, 64'd1);
      end
      tick();
    end

    // 2: basic write-back, x0 immune
    wb(0, 5'd5, 64'hDEAD_BEEF);
    wb(1, 5'd6, 64'hCAFE_0000_1234_5678);
    set_rs(5'd5, 5'd6);
    expect_out("wb_same_r0", S_R0, BYP ? 64'hDEAD_BEEF : 64'd0);
    expect_out("wb_same_r1", S_R1, BYP ? 64'hCAFE_0000_1234_5678 : 64'd0);
    tick();
    wb(0, 5'd0, 64'h1234);
    set_rs(5'd5, 5'd0);
    expect_out("wb_x5", S_R0, 64'hDEAD_BEEF);
    expect_out("x0_bypass", S_R1, 64'd0);
    tick();
    set_rs(5'd0, 5'd6);
    expect_out("x0_zero", S_R0, 64'd0);
    expect_out("wb_x6", S_R1, 64'hCAFE_0000_1234_5678);
    tick();

    // 3: issue, WAW stall, release by write-back
    iss(5'd7);
    expect_out("iss7_rdy", S_ISS, 64'd1);
    tick();
    set_rs(5'd7, 5'd0);
    iss(5'd7);
    expect_out("x7_busy", S_RDY0, 64'd0);
    expect_out("bcnt1", S_BCNT, 64'd1);
    expect_out("waw_stall", S_ISS, 64'd0);
    tick();
    wb(1, 5'd7, 64'h55);
    set_rs(5'd7, 5'd7);
    iss_rd = 5'd7;
    expect_out("stall_pre_edge", S_ISS, 64'd0);
    expect_out("x7_same_rdy", S_RDY0, BYP ? 64'd1 : 64'd0);
    expect_out("x7_same_r", S_R0, BYP ? 64'h55 : 64'd0);
    expect_out("bcnt1_hold", S_BCNT, 64'd1);
    tick();
    set_rs(5'd7, 5'd0);
    expect_out("x7_val", S_R0, 64'h55);
    expect_out("x7_rdy", S_RDY0, 64'd1);
    expect_out("iss7_free", S_ISS, 64'd1);
    expect_out("bcnt0", S_BCNT, 64'd0);
    tick();
    iss(5'd0);
    expect_out("iss_x0_rdy", S_ISS, 64'd1);
    tick();
    expect_out("iss_x0_nobusy", S_BCNT, 64'd0);
    tick();

    // 4: both ports to the same register, LSU wins
    iss(5'd3);
    tick();
    wb(0, 5'd3, 64'h11);
    wb(1, 5'd3, 64'h22);
    set_rs(5'd3, 5'd3);
    expect_out("dual_bcnt", S_BCNT, 64'd1);
    expect_out("dual_same_r", S_R0, BYP ? 64'h22 : 64'd0);
    expect_out("dual_same_rdy", S_RDY1, BYP ? 64'd1 : 64'd0);
    tick();
    set_rs(5'd3, 5'd0);
    expect_out("dual_x3", S_R0, 64'h22);
    expect_out("dual_rdy", S_RDY0, 64'd1);
    expect_out("dual_bcnt0", S_BCNT, 64'd0);
    tick();

    // 5: flush with concurrent write-back and issue
    iss(5'd1);
    expect_out("iss1", S_ISS, 64'd1);
    tick();
    iss(5'd2);
    tick();
    iss(5'd3);
    expect_out("iss3", S_ISS, 64'd1);
    tick();
    flush = 1'b1;
    wb(0, 5'd2, 64'h99);
    iss(5'd4);
    set_rs(5'd2, 5'd1);
    expect_out("flush_iss", S_ISS, 64'd0);
    expect_out("flush_bcnt3", S_BCNT, 64'd3);
    expect_out("flush_x2_rdy", S_RDY0, BYP ? 64'd1 : 64'd0);
    expect_out("flush_x1_rdy", S_RDY1, 64'd0);
    tick();
    set_rs(5'd2, 5'd4);
    iss_rd = 5'd4;
    expect_out("post_flush_bcnt", S_BCNT, 64'd0);
    expect_out("post_flush_x2", S_R0, 64'h99);
    expect_out("post_flush_rdy2", S_RDY0, 64'd1);
    expect_out("post_flush_rdy4", S_RDY1, 64'd1);
    expect_out("post_flush_iss", S_ISS, 64'd1);
    tick();

    // 6: bypass behaviour on a busy register
    wb(0, 5'd9, 64'h77);
    tick();
    iss(5'd9);
    tick();
    wb(0, 5'd9, 64'hAB);
    set_rs(5'd9, 5'd9);
    expect_out("byp_r0", S_R0, BYP ? 64'hAB : 64'h77);
    expect_out("byp_r1", S_R1, BYP ? 64'hAB : 64'h77);
    expect_out("byp_rdy0", S_RDY0, BYP ? 64'd1 : 64'd0);
    expect_out("byp_rdy1", S_RDY1, BYP ? 64'd1 : 64'd0);
    tick();
    set_rs(5'd9, 5'd0);
    expect_out("x9_val", S_R0, 64'hAB);
    expect_out("x9_rdy", S_RDY0, 64'd1);
    tick();

    // asynchronous reset mid-sequence
    iss(5'd10);
    wb(0, 5'd12, 64'h5);
    tick();
    iss(5'd11);
    expect_out("pre_rst_bcnt", S_BCNT, 64'd1);
    tick();
    set_rs(5'd12, 5'd10);
    iss_rd = 5'd10;
    #2;
    rst = 1'b1;
    #1;
    expect_out("arst_r0", S_R0, 64'd0);
    expect_out("arst_rdy1", S_RDY1, 64'd1);
    expect_out("arst_bcnt", S_BCNT, 64'd0);
    expect_out("arst_iss", S_ISS, 64'd1);
    tick();
    rst = 1'b0;
    set_rs(5'd6, 5'd5);
    expect_out("arst_x6", S_R0, 64'd0);
    expect_out("arst_x5", S_R1, 64'd0);
    tick();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d left want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
